// File: rtl/mux_n_reg.sv
// N-channel registered mux with valid/ready on every channel and the output.
// Fixed-select or round-robin grant; counts completed input transfers.
module mux_n_reg #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int SELW  = 2,
    parameter int CNTW  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNTW-1:0]    xfer_cnt
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [CNTW-1:0]  xfer_cnt_q, xfer_cnt_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             load;
    logic             grant;
    logic [SELW-1:0]  g;
    logic [WIDTH-1:0] g_data;
    logic             xfer;

    assign load = ~out_valid_q | out_ready;

    // Round-robin: scan rr_ptr..N-1 first, then 0..rr_ptr-1.
    always_comb begin
        grant = 1'b0;
        g     = '0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    grant = 1'b1;
                    g     = SELW'(i);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!grant && SELW'(i) >= rr_ptr_q && in_valid[i]) begin
                    grant = 1'b1;
                    g     = SELW'(i);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!grant && SELW'(i) < rr_ptr_q && in_valid[i]) begin
                    grant = 1'b1;
                    g     = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        g_data = '0;
        for (int i = 0; i < N; i++) begin
            if (g == SELW'(i)) begin
                g_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer     = rst_n & load & grant;
    assign in_ready = xfer ? (N'(1) << g) : '0;

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        xfer_cnt_d  = xfer_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = g_data;
                out_ch_d   = g;
                xfer_cnt_d = xfer_cnt_q + CNTW'(1);
                rr_ptr_d   = (g == SELW'(N-1)) ? '0 : g + SELW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            xfer_cnt_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            xfer_cnt_q  <= xfer_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
Parametrised N-channel, WIDTH-bit multiplexer with a registered output stage and valid/ready handshakes on every input channel and on the output. It is the next generation of the team's 2:1 32-bit select mux. It adds two things: an explicit-select mode and a round-robin arbitration mode, plus a transfer counter. It sits between feature-extraction stages of the OCR datapath, where several producers feed one 32-bit consumer.

Parameters:
N, 4, number of input channels (2..16)
WIDTH, 32, data width per channel
SELW, 2, select/channel-index width; must equal max(1, ceil(log2 N))
CNTW, 16, width of the transfer counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready; at most one bit high per cycle
sel  input  SELW  channel index used in fixed mode
mode  input  1  0 = fixed select by sel; 1 = round-robin over valid channels
out_data  output  WIDTH  registered output data
out_ch  output  SELW  index of the channel that supplied out_data
out_valid  output  1  output register holds a word
out_ready  input  1  consumer accepts the word
xfer_cnt  output  CNTW  number of completed input transfers, wraps modulo 2^CNTW

Behaviour:
- Reset is synchronous on rst_n low at a clk edge. It sets out_valid=0, out_data=0, out_ch=0, xfer_cnt=0 and rr_ptr=0.
- While rst_n is low, in_ready is forced to all zeros.
- load = ~out_valid | out_ready. The output register can take a new word when it is empty or is being drained in the same cycle.
- Grant is combinational.
  - mode=0: the granted channel is g=sel, but only when sel<N and in_valid[sel]=1. If sel>=N, there is no grant, and no channel is ever accepted.
  - mode=1: g is the first channel i with in_valid[i]=1, searching cyclically from rr_ptr upward (rr_ptr, rr_ptr+1, ..., N-1, 0, ...). There is no grant if no channel is valid.
- in_ready[g]=1 only when load=1 and a grant exists. All other in_ready bits are 0.
- in_ready may depend on in_valid and sel. Producers must not make in_valid depend on in_ready.
- A transfer occurs when in_valid[g] and in_ready[g] are both high. At the next edge:
  - out_data <= slice g of in_data, out_ch <= g, out_valid <= 1
  - xfer_cnt <= xfer_cnt+1, wrapping at 2^CNTW-1 -> 0
  - rr_ptr <= g+1, or 0 if g=N-1
- rr_ptr advances only on a transfer, and in both modes. Switching mode therefore resumes round-robin from the channel after the last one served.
- If load=1 and there is no transfer: out_valid <= 0; out_data and out_ch hold their values.
- If load=0 (out_valid=1 and out_ready=0): all output registers hold, and in_ready is all zeros.
- Latency is one cycle from input transfer to out_valid. Throughput is one word per cycle when out_ready is held high.
- Simultaneous drain and fill (out_valid=1, out_ready=1, input transfer) replaces the word with no bubble.
- mode and sel changes take effect in the same cycle's grant. A word already in the output register is unaffected.
- A reset asserted mid-stream discards the held word, with out_valid=0 at the next edge. No transfer is counted in the reset cycle.
- N not a power of two: indices >= N are never granted, and rr_ptr never takes a value >= N.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with in_valid=4'hF -> in_ready=0, out_valid=0, out_data=0, xfer_cnt=0.
2. Fixed mode: mode=0, sel=2, in_data ch2=32'hA5A5_0002, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100. Next cycle: out_data=32'hA5A5_0002, out_ch=2, xfer_cnt=1. With sel=1 and in_valid=4'b0100: no grant, and out_valid drops to 0 on the next edge.
3. Round-robin: mode=1, all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles. After 6 transfers, xfer_cnt=6.
4. Backpressure: out_valid=1, out_ready=0 for 5 cycles while ch1 is valid -> in_ready=0, and out_data/out_ch are stable. out_ready=1 -> ch1 is accepted in that same cycle, and its word appears on the next edge.
5. Sparse round-robin: mode=1, rr_ptr=1, in_valid=4'b1001 -> ch3 is granted before ch0. Then, with only ch0 valid -> ch0 is granted and rr_ptr=1.
6. Wrap and mid-stream reset: CNTW=4, 16 transfers -> xfer_cnt returns to 0. Assert rst_n=0 while out_valid=1 -> out_valid=0 on the next edge and rr_ptr=0, and the first grant after reset in mode 1 is the lowest valid channel.
